// File: rtl/mcc_exception_unit.sv
// Exception / interrupt unit for the multi-cycle computer.
// Provides NUM_IRQ maskable, synchronised interrupt channels, two synchronous
// exception sources, fixed-priority arbitration, EPC/Cause capture, handler
// tracking and return-from-exception. A second synchronous exception while an
// exception is being taken or handled locks the unit in FAULT until reset.
module mcc_exception_unit #(
  parameter int DATA_BUS_WIDTH    = 24,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int NUM_IRQ           = 4,
  parameter int CAUSE_WIDTH       = 4,
  parameter logic [ADDRESS_BUS_WIDTH-1:0] VECTOR_ADDRESS = 12'h040
) (
  input  logic                         mainClock,
  input  logic                         reset,
  input  logic [NUM_IRQ-1:0]           irqReq,
  input  logic                         irqEnableWrite,
  input  logic [NUM_IRQ-1:0]           irqEnableData,
  input  logic                         excIllegal,
  input  logic                         excOverflow,
  input  logic                         instrBoundary,
  input  logic [ADDRESS_BUS_WIDTH-1:0] pcAddress,
  input  logic                         eret,
  output logic                         takeException,
  output logic [ADDRESS_BUS_WIDTH-1:0] vectorAddress,
  output logic [ADDRESS_BUS_WIDTH-1:0] returnAddress,
  output logic [DATA_BUS_WIDTH-1:0]    EPCReg,
  output logic [CAUSE_WIDTH-1:0]       causeReg,
  output logic [NUM_IRQ-1:0]           irqAck,
  output logic [NUM_IRQ-1:0]           irqPending,
  output logic                         inHandler,
  output logic                         doubleFault
);

  // FSM encoding
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_TAKE    = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // Cause codes for the synchronous sources; irq i reports 4+i
  localparam logic [CAUSE_WIDTH-1:0] C_ILLEGAL  = CAUSE_WIDTH'(1);
  localparam logic [CAUSE_WIDTH-1:0] C_OVERFLOW = CAUSE_WIDTH'(2);

  logic [1:0]                  r_state;
  logic [DATA_BUS_WIDTH-1:0]   r_epc;
  logic [CAUSE_WIDTH-1:0]      r_cause;
  logic [NUM_IRQ-1:0]          r_pending;
  logic [NUM_IRQ-1:0]          r_enable;
  logic                        r_double_fault;

  logic [NUM_IRQ-1:0]          w_rise;
  logic [NUM_IRQ-1:0]          w_ack;
  logic [NUM_IRQ-1:0]          w_eligible;
  logic                        w_irq_valid;
  logic [CAUSE_WIDTH-1:0]      w_irq_code;
  logic                        w_sync_exc;
  logic [1:0]                  w_next_state;
  logic                        w_capture;
  logic [CAUSE_WIDTH-1:0]      w_capture_code;

  genvar gi;

  // Per-channel two-flop synchroniser plus one delayed copy for rising-edge detection.
  // A request rising before edge 1 produces w_rise high ahead of edge 3.
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
      logic r_meta;
      logic r_level;
      logic r_level_d;

      // Shift the raw request through the synchroniser chain
      always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
          r_meta    <= 1'b0;
          r_level   <= 1'b0;
          r_level_d <= 1'b0;
        end else begin
          r_meta    <= irqReq[gi];
          r_level   <= r_meta;
          r_level_d <= r_level;
        end
      end

      assign w_rise[gi] = r_level & ~r_level_d;

      // Acknowledge only the channel that was captured, only during TAKE
      assign w_ack[gi] = (r_state == ST_TAKE) && (r_cause == CAUSE_WIDTH'(gi + 4));
    end
  endgenerate

  assign w_eligible = r_pending & r_enable;
  assign w_sync_exc = excIllegal | excOverflow;

  // Lowest-index eligible interrupt wins
  always_comb begin
    w_irq_valid = 1'b0;
    w_irq_code  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_irq_valid = 1'b1;
        w_irq_code  = CAUSE_WIDTH'(i + 4);
      end
    end
  end

  // Next-state and capture decision; sync exceptions need no instruction boundary
  always_comb begin
    w_next_state   = r_state;
    w_capture      = 1'b0;
    w_capture_code = '0;
    case (r_state)
      ST_RUN: begin
        if (excIllegal) begin
          w_next_state   = ST_TAKE;
          w_capture      = 1'b1;
          w_capture_code = C_ILLEGAL;
        end else if (excOverflow) begin
          w_next_state   = ST_TAKE;
          w_capture      = 1'b1;
          w_capture_code = C_OVERFLOW;
        end else if (w_irq_valid && instrBoundary) begin
          w_next_state   = ST_TAKE;
          w_capture      = 1'b1;
          w_capture_code = w_irq_code;
        end
      end
      ST_TAKE: begin
        w_next_state = w_sync_exc ? ST_FAULT : ST_HANDLER;
      end
      ST_HANDLER: begin
        if (w_sync_exc) begin
          w_next_state = ST_FAULT;
        end else if (eret) begin
          w_next_state = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // FSM state, EPC/Cause capture and sticky double-fault flag
  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_epc          <= '0;
      r_cause        <= '0;
      r_double_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_epc   <= DATA_BUS_WIDTH'(pcAddress);
        r_cause <= w_capture_code;
      end
      if (w_next_state == ST_FAULT) begin
        r_double_fault <= 1'b1;
      end
    end
  end

  // Pending latch (a new rising edge beats a same-cycle ack) and enable mask
  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack) | w_rise;
      if (irqEnableWrite) begin
        r_enable <= irqEnableData;
      end
    end
  end

  // Outputs are decoded from state so an asynchronous reset removes them at once
  assign takeException = (r_state == ST_TAKE);
  assign inHandler     = (r_state == ST_TAKE) || (r_state == ST_HANDLER);
  assign irqAck        = w_ack;
  assign irqPending    = r_pending;
  assign EPCReg        = r_epc;
  assign causeReg      = r_cause;
  assign returnAddress = r_epc[ADDRESS_BUS_WIDTH-1:0];
  assign vectorAddress = VECTOR_ADDRESS;
  assign doubleFault   = r_double_fault;

endmodule

// File: tb/tb_mcc_exception_unit.sv
// Testbench for mcc_exception_unit: directed scenarios followed by a
// randomized run checked against a behavioural model of the unit.
module tb_mcc_exception_unit;

  logic        mainClock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irqReq = '0;
  logic        irqEnableWrite = 1'b0;
  logic [3:0]  irqEnableData = '0;
  logic        excIllegal = 1'b0;
  logic        excOverflow = 1'b0;
  logic        instrBoundary = 1'b0;
  logic [11:0] pcAddress = '0;
  logic        eret = 1'b0;
  logic        takeException;
  logic [11:0] vectorAddress;
  logic [11:0] returnAddress;
  logic [23:0] EPCReg;
  logic [3:0]  causeReg;
  logic [3:0]  irqAck;
  logic [3:0]  irqPending;
  logic        inHandler;
  logic        doubleFault;

  int n_checks = 0;
  int n_fail   = 0;

  mcc_exception_unit dut (
    .mainClock(mainClock), .reset(reset), .irqReq(irqReq),
    .irqEnableWrite(irqEnableWrite), .irqEnableData(irqEnableData),
    .excIllegal(excIllegal), .excOverflow(excOverflow),
    .instrBoundary(instrBoundary), .pcAddress(pcAddress), .eret(eret),
    .takeException(takeException), .vectorAddress(vectorAddress),
    .returnAddress(returnAddress), .EPCReg(EPCReg), .causeReg(causeReg),
    .irqAck(irqAck), .irqPending(irqPending), .inHandler(inHandler),
    .doubleFault(doubleFault)
  );

  always #5 mainClock = ~mainClock;

  // ---------------- behavioural model (used by the random test) ----------------
  // mode: 0 running, 1 taking, 2 in handler, 3 faulted
  int          m_mode;
  logic [3:0]  m_pend, m_en, m_cause;
  logic [23:0] m_epc;
  logic [3:0]  m_hist [0:2];   // irqReq seen at the last three edges, newest first

  task automatic model_reset();
    m_mode = 0; m_pend = '0; m_en = '0; m_cause = '0; m_epc = '0;
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
  endtask

  function automatic logic [3:0] model_ack();
    if (m_mode == 1 && m_cause >= 4) return 4'(1 << (int'(m_cause) - 4));
    return 4'b0000;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [3:0] rise, ack, elig;
    int code;
    rise = m_hist[1] & ~m_hist[2];
    ack  = model_ack();
    elig = m_pend & m_en;
    code = 0;
    for (int i = 3; i >= 0; i--) if (elig[i]) code = 4 + i;
    case (m_mode)
      0: begin
        if (excIllegal)                      begin m_mode = 1; m_cause = 4'd1; m_epc = {12'h000, pcAddress}; end
        else if (excOverflow)                begin m_mode = 1; m_cause = 4'd2; m_epc = {12'h000, pcAddress}; end
        else if (code != 0 && instrBoundary) begin m_mode = 1; m_cause = 4'(code); m_epc = {12'h000, pcAddress}; end
      end
      1: m_mode = (excIllegal || excOverflow) ? 3 : 2;
      2: if (excIllegal || excOverflow) m_mode = 3; else if (eret) m_mode = 0;
      default: m_mode = 3;
    endcase
    m_pend = (m_pend & ~ack) | rise;
    if (irqEnableWrite) m_en = irqEnableData;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = irqReq;
  endtask

  task automatic tick();
    @(negedge mainClock);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({takeException, causeReg, EPCReg, irqAck, irqPending, inHandler, doubleFault} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: take=%b cause=%h epc=%h ack=%b pend=%b inh=%b df=%b, required all 0",
               takeException, causeReg, EPCReg, irqAck, irqPending, inHandler, doubleFault);
    end
    n_checks++;
    if (vectorAddress !== 12'h040) begin
      n_fail++; $display("FAIL reset_vector: got %h, required 040", vectorAddress);
    end
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_irq_basic();
    irqEnableWrite = 1'b1; irqEnableData = 4'b0010; instrBoundary = 1'b1; pcAddress = 12'h804;
    tick();
    irqEnableWrite = 1'b0;
    irqReq[1] = 1'b1;               // rises before edge 1
    repeat (3) tick();              // after edge 3
    n_checks++;
    if (irqPending !== 4'b0010 || takeException !== 1'b0) begin
      n_fail++; $display("FAIL irq_edge3: pend=%b take=%b, required pend=0010 take=0", irqPending, takeException);
    end
    tick();                         // after edge 4
    n_checks++;
    if (takeException !== 1'b1 || causeReg !== 4'd5 || EPCReg !== 24'h000804 || irqAck !== 4'b0010 || inHandler !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_take: take=%b cause=%0d epc=%h ack=%b inh=%b, required 1 5 000804 0010 1",
               takeException, causeReg, EPCReg, irqAck, inHandler);
    end
    tick();
    n_checks++;
    if (takeException !== 1'b0 || irqAck !== 4'b0000 || irqPending !== 4'b0000 || inHandler !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_handler: take=%b ack=%b pend=%b inh=%b, required 0 0000 0000 1",
               takeException, irqAck, irqPending, inHandler);
    end
    eret = 1'b1; tick(); eret = 1'b0;
    irqReq = '0; instrBoundary = 1'b0;
    repeat (3) tick();
    $display("test_irq_basic done");
  endtask

  task automatic test_exc_priority();
    irqEnableWrite = 1'b1; irqEnableData = 4'b0001;
    tick();
    irqEnableWrite = 1'b0; irqReq[0] = 1'b1; instrBoundary = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (irqPending !== 4'b0001 || takeException !== 1'b0) begin
      n_fail++; $display("FAIL prio_pending: pend=%b take=%b, required 0001 0", irqPending, takeException);
    end
    excIllegal = 1'b1; instrBoundary = 1'b1; pcAddress = 12'h123;
    tick();
    excIllegal = 1'b0; instrBoundary = 1'b0;
    n_checks++;
    if (takeException !== 1'b1 || causeReg !== 4'd1 || irqAck !== 4'b0000 || irqPending !== 4'b0001 || EPCReg !== 24'h000123) begin
      n_fail++;
      $display("FAIL prio_illegal: take=%b cause=%0d ack=%b pend=%b epc=%h, required 1 1 0000 0001 000123",
               takeException, causeReg, irqAck, irqPending, EPCReg);
    end
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    n_checks++;
    if (inHandler !== 1'b0 || irqPending !== 4'b0001) begin
      n_fail++; $display("FAIL prio_eret: inh=%b pend=%b, required 0 0001", inHandler, irqPending);
    end
    instrBoundary = 1'b1; pcAddress = 12'h200;
    tick();
    instrBoundary = 1'b0;
    n_checks++;
    if (takeException !== 1'b1 || causeReg !== 4'd4 || irqAck !== 4'b0001 || EPCReg !== 24'h000200) begin
      n_fail++;
      $display("FAIL prio_irq0: take=%b cause=%0d ack=%b epc=%h, required 1 4 0001 000200",
               takeException, causeReg, irqAck, EPCReg);
    end
    tick();
    n_checks++;
    if (irqPending !== 4'b0000) begin
      n_fail++; $display("FAIL prio_cleared: pend=%b, required 0000", irqPending);
    end
    eret = 1'b1; tick(); eret = 1'b0;
    irqReq = '0;
    repeat (3) tick();
    $display("test_exc_priority done");
  endtask

  task automatic test_masked();
    bit seen;
    bit found;
    irqEnableWrite = 1'b1; irqEnableData = 4'b0000;
    tick();
    irqEnableWrite = 1'b0; irqReq[2] = 1'b1; instrBoundary = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (takeException) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || irqPending !== 4'b0100) begin
      n_fail++; $display("FAIL masked_hold: take_seen=%b pend=%b, required 0 0100", seen, irqPending);
    end
    irqEnableWrite = 1'b1; irqEnableData = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      irqEnableWrite = 1'b0;
      if (takeException) begin found = 1'b1; break; end
    end
    n_checks++;
    if (found !== 1'b1 || causeReg !== 4'd6) begin
      n_fail++; $display("FAIL masked_release: take_seen=%b cause=%0d, required 1 6", found, causeReg);
    end
    instrBoundary = 1'b0; irqReq = '0;
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    repeat (3) tick();
    $display("test_masked done");
  endtask

  task automatic test_double_fault();
    excOverflow = 1'b1; pcAddress = 12'h3c0;
    tick();
    excOverflow = 1'b0;
    n_checks++;
    if (takeException !== 1'b1 || causeReg !== 4'd2) begin
      n_fail++; $display("FAIL df_take: take=%b cause=%0d, required 1 2", takeException, causeReg);
    end
    tick();
    excOverflow = 1'b1;
    tick();
    excOverflow = 1'b0;
    n_checks++;
    if (doubleFault !== 1'b1 || takeException !== 1'b0 || inHandler !== 1'b0) begin
      n_fail++; $display("FAIL df_enter: df=%b take=%b inh=%b, required 1 0 0", doubleFault, takeException, inHandler);
    end
    eret = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (doubleFault !== 1'b1 || takeException !== 1'b0 || inHandler !== 1'b0) begin
        n_fail++; $display("FAIL df_eret_ignored: df=%b take=%b inh=%b, required 1 0 0", doubleFault, takeException, inHandler);
      end
    end
    eret = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({takeException, causeReg, EPCReg, irqAck, irqPending, inHandler, doubleFault} !== 35'd0) begin
      n_fail++;
      $display("FAIL df_reset: take=%b cause=%h epc=%h ack=%b pend=%b inh=%b df=%b, required all 0",
               takeException, causeReg, EPCReg, irqAck, irqPending, inHandler, doubleFault);
    end
    tick();
    reset = 1'b1;
    excIllegal = 1'b1;
    tick();
    excIllegal = 1'b0;
    n_checks++;
    if (takeException !== 1'b1 || causeReg !== 4'd1 || doubleFault !== 1'b0) begin
      n_fail++; $display("FAIL df_run_after_reset: take=%b cause=%0d df=%b, required 1 1 0", takeException, causeReg, doubleFault);
    end
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    $display("test_double_fault done");
  endtask

  task automatic test_eret();
    excIllegal = 1'b1; pcAddress = 12'habc;
    tick();
    excIllegal = 1'b0;
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    pcAddress = 12'h555; eret = 1'b1;
    tick();
    eret = 1'b0;
    n_checks++;
    if (inHandler !== 1'b0 || takeException !== 1'b0 || EPCReg !== 24'h000abc) begin
      n_fail++; $display("FAIL eret_in_run: inh=%b take=%b epc=%h, required 0 0 000abc", inHandler, takeException, EPCReg);
    end
    excIllegal = 1'b1; pcAddress = 12'hdef;
    tick();
    excIllegal = 1'b0;
    tick();
    n_checks++;
    if (inHandler !== 1'b1) begin
      n_fail++; $display("FAIL eret_handler_entry: inh=%b, required 1", inHandler);
    end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    n_checks++;
    if (inHandler !== 1'b0 || returnAddress !== 12'hdef) begin
      n_fail++; $display("FAIL eret_return: inh=%b ret=%h, required 0 def", inHandler, returnAddress);
    end
    $display("test_eret done");
  endtask

  task automatic test_reset_in_take();
    bit found;
    irqEnableWrite = 1'b1; irqEnableData = 4'b1000;
    tick();
    irqEnableWrite = 1'b0; irqReq[3] = 1'b1; instrBoundary = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (takeException) begin found = 1'b1; break; end
    end
    n_checks++;
    if (found !== 1'b1 || irqAck !== 4'b1000 || irqPending !== 4'b1000 || causeReg !== 4'd7) begin
      n_fail++; $display("FAIL take_irq3: seen=%b ack=%b pend=%b cause=%0d, required 1 1000 1000 7",
                         found, irqAck, irqPending, causeReg);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (takeException !== 1'b0 || irqAck !== 4'b0000 || irqPending !== 4'b0000 || inHandler !== 1'b0 || causeReg !== 4'd0) begin
      n_fail++; $display("FAIL reset_in_take: take=%b ack=%b pend=%b inh=%b cause=%0d, required 0 0000 0000 0 0",
                         takeException, irqAck, irqPending, inHandler, causeReg);
    end
    irqReq = '0; instrBoundary = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    $display("test_reset_in_take done");
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    logic [54:0] got, exp;
    int errs;
    errs = 0;
    reset = 1'b0;
    model_reset();
    tick();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!reset) reset = 1'b1;
      else if (m_mode == 3 || $urandom_range(0, 299) == 0) reset = 1'b0;
      if ($urandom_range(0, 7) == 0) irqReq[$urandom_range(0, 3)] ^= 1'b1;
      irqEnableWrite = ($urandom_range(0, 9) == 0);
      irqEnableData  = 4'($urandom);
      excIllegal     = ($urandom_range(0, 29) == 0);
      excOverflow    = ($urandom_range(0, 29) == 0);
      instrBoundary  = $urandom_range(0, 1) != 0;
      eret           = ($urandom_range(0, 5) == 0);
      pcAddress      = 12'($urandom);
      if (!reset) model_reset(); else model_step();
      tick();
      exp = {(m_mode == 1), m_cause, m_epc, model_ack(), m_pend,
             (m_mode == 1 || m_mode == 2), (m_mode == 3), m_epc[11:0]};
      got = {takeException, causeReg, EPCReg, irqAck, irqPending, inHandler, doubleFault, returnAddress};
      n_checks++;
      if (got !== exp) begin
        n_fail++; errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: take/cause/epc/ack/pend/inh/df/ret got %h, required %h", cyc, got, exp);
      end
    end
    excIllegal = 1'b0; excOverflow = 1'b0; eret = 1'b0; irqEnableWrite = 1'b0;
    $display("test_random done: 1500 cycles, %0d differing", errs);
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_exc_priority();
    test_masked();
    test_double_fault();
    test_eret();
    test_reset_in_take();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
